// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply unit.
//   - ALUOp2 codes decoded by the unit (OP_*).
//   - FSM state encoding (state_e).
//   - is_mult_op(): true for codes that start a multi-cycle multiply.
package hilo_pkg;

  localparam int unsigned OP_CODE_W = 5;

  localparam logic [OP_CODE_W-1:0] OP_MUL  = 5'b00010;
  localparam logic [OP_CODE_W-1:0] OP_MADD = 5'b01011;
  localparam logic [OP_CODE_W-1:0] OP_MSUB = 5'b01100;
  localparam logic [OP_CODE_W-1:0] OP_MTHI = 5'b10010;
  localparam logic [OP_CODE_W-1:0] OP_MTLO = 5'b10011;
  localparam logic [OP_CODE_W-1:0] OP_MFHI = 5'b10100;
  localparam logic [OP_CODE_W-1:0] OP_MFLO = 5'b10101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2
  } state_e;

  function automatic logic is_mult_op(input logic [OP_CODE_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mult_iter_core.sv
// mult_iter_core: unsigned iterative shift-add multiplier (datapath only).
//
// Build option: MULT_RADIX4_EN
//   undefined -> radix-2, one multiplier bit per step, WIDTH steps.
//   defined   -> radix-4, two multiplier bits per step, WIDTH/2 steps;
//                3*mcand is precomputed in the load cycle.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture mcand/mplier, clear product and step counter
//   step        perform one iteration (ignored when load is high)
//   mcand       unsigned multiplicand magnitude
//   mplier      unsigned multiplier magnitude
//   product     running / final 2*WIDTH-bit unsigned product
//   last_step   high while the step that completes the product is pending
module mult_iter_core
  #(parameter int WIDTH = 32)
  (input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic [2*WIDTH-1:0] product,
   output logic               last_step);

`ifdef MULT_RADIX4_EN
  localparam int STEPS = WIDTH / 2;
`else
  localparam int STEPS = WIDTH;
`endif
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Low half starts as the multiplier and is shifted out as the
  // accumulated partial sum is shifted in from the top.
  logic [2*WIDTH-1:0] prod_q,  prod_d;

`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0] b3_q, b3_d;
  logic [WIDTH+1:0] pp;
  logic [WIDTH+1:0] sum;

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    b3_d    = b3_q;
    unique case (prod_q[1:0])
      2'b00:   pp = '0;
      2'b01:   pp = {2'b00, mcand_q};
      2'b10:   pp = {1'b0, mcand_q, 1'b0};
      default: pp = b3_q;
    endcase
    // Upper half (< 2^W) plus 3*mcand (< 3*2^W) fits in WIDTH+2 bits.
    sum = {2'b00, prod_q[2*WIDTH-1:WIDTH]} + pp;
    if (load) begin
      mcand_d = mcand;
      b3_d    = {2'b00, mcand} + {1'b0, mcand, 1'b0};
      prod_d  = {{WIDTH{1'b0}}, mplier};
      cnt_d   = '0;
    end else if (step) begin
      prod_d  = {sum, prod_q[WIDTH-1:2]};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b3_q <= '0;
    end else begin
      b3_q <= b3_d;
    end
  end
`else
  logic [WIDTH:0] sum;

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
            + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    if (load) begin
      mcand_d = mcand;
      prod_d  = {{WIDTH{1'b0}}, mplier};
      cnt_d   = '0;
    end else if (step) begin
      prod_d  = {sum, prod_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign product   = prod_q;
  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

endmodule

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: multi-cycle multiply / multiply-accumulate unit holding
// the architectural HI/LO registers. Sits in EX next to the ALU.
//
// Build option: MULT_RADIX4_EN selects the radix-4 iteration core
// (Done in cycle WIDTH/2+2 instead of WIDTH+2). Everything else is equal.
//
// Ports:
//   Clk     clock, rising edge
//   Rst     asynchronous active-low reset
//   Start   sample ALUOp2/A/B/Signed this cycle (ignored while Busy)
//   ALUOp2  op code from ALU control
//   Signed  1 = signed operands, 0 = unsigned
//   A, B    operands rs, rt
//   Busy    multiply in progress
//   Done    one-cycle pulse, HI/LO carry the new value in the same cycle
//   HI, LO  architectural registers
//   Result  combinational: HI for MFHI, LO for MFLO/MUL, else 0
//
// Handshake: Start is a request that is accepted only on a rising edge
// where the unit is idle (Busy low); a request seen while Busy is dropped
// with no side effect. Done marks completion for exactly one cycle and the
// unit is idle again in that cycle, so a new Start there is accepted.
//
// FSM state is held in state_q (IDLE/MUL/ACC) for observation.
module hilo_mult_unit
  import hilo_pkg::*;
  #(parameter int WIDTH = 32,
    parameter int OP_W  = 5)
  (input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [OP_W-1:0]  ALUOp2,
   input  logic             Signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] Result);

  state_e             state_q, state_d;
  logic [OP_W-1:0]    op_q,    op_d;
  logic               neg_q,   neg_d;
  logic               done_q,  done_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;

  logic               core_load;
  logic               core_step;
  logic               core_last;
  logic [2*WIDTH-1:0] core_product;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_signed;
  logic [2*WIDTH-1:0] hilo_new;

  // Magnitudes as unsigned WIDTH-bit values; the most negative input maps
  // to 2^(WIDTH-1), which still fits without an extra bit.
  assign a_mag = (Signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
  assign b_mag = (Signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;

  mult_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (Clk),
    .rst_n     (Rst),
    .load      (core_load),
    .step      (core_step),
    .mcand     (b_mag),
    .mplier    (a_mag),
    .product   (core_product),
    .last_step (core_last)
  );

  assign prod_signed = neg_q ? (~core_product + (2*WIDTH)'(1)) : core_product;

  always_comb begin
    hilo_new = prod_signed;
    if (op_q == OP_MADD) begin
      hilo_new = {hi_q, lo_q} + prod_signed;
    end else if (op_q == OP_MSUB) begin
      hilo_new = {hi_q, lo_q} - prod_signed;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if (is_mult_op(ALUOp2)) begin
            core_load = 1'b1;
            op_d      = ALUOp2;
            neg_d     = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            state_d   = MUL;
          end else if (ALUOp2 == OP_MTHI) begin
            hi_d = A;
          end else if (ALUOp2 == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      MUL: begin
        core_step = 1'b1;
        if (core_last) begin
          state_d = ACC;
        end
      end
      ACC: begin
        {hi_d, lo_d} = hilo_new;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    Result = '0;
    if (ALUOp2 == OP_MFHI) begin
      Result = hi_q;
    end else if ((ALUOp2 == OP_MFLO) || (ALUOp2 == OP_MUL)) begin
      Result = lo_q;
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit: directed vector table for hilo_mult_unit followed by
// hand-written sequences for start-while-busy, reset mid-operation and
// back-to-back issue in the Done cycle.
module tb_hilo_mult_unit;
  import hilo_pkg::*;

  localparam int W = 32;
`ifdef MULT_RADIX4_EN
  localparam int LAT = W / 2 + 2;
`else
  localparam int LAT = W + 2;
`endif

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [4:0]   ALUOp2;
  logic         Signed;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic [W-1:0] Result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 Clk = ~Clk;

  hilo_mult_unit #(.WIDTH(W), .OP_W(5)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .ALUOp2 (ALUOp2),
    .Signed (Signed),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .HI     (HI),
    .LO     (LO),
    .Result (Result)
  );

  typedef struct {
    logic [4:0]   op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_res;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // ---------------- clock / reset helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive a one-cycle Start; returns the cycle number of the Start cycle.
  task automatic issue(input logic [4:0] op, input logic sg,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output int t0);
    ALUOp2 = op;
    Signed = sg;
    A      = a;
    B      = b;
    Start  = 1'b1;
    t0     = cyc;
    tick();
    Start  = 1'b0;
    A      = '0;
    B      = '0;
  endtask

  // Wait (bounded) for Done; dc is the Done cycle relative to Start, -1 if
  // none arrived. busy_ok drops if Busy was low in any cycle before Done.
  task automatic wait_done(input int t0, output int dc, output bit busy_ok);
    dc      = -1;
    busy_ok = 1'b1;
    while (cyc - t0 <= LAT + 4) begin
      if (Done) begin
        dc = cyc - t0;
        return;
      end
      if (!Busy) busy_ok = 1'b0;
      tick();
    end
  endtask

  initial begin
    int t0;
    int t1;
    int dc;
    bit bok;
    bit seen;

    vecs[0] = '{OP_MUL,  1'b1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFEB};
    vecs[1] = '{OP_MUL,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001};
    vecs[2] = '{OP_MUL,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[3] = '{OP_MTHI, 1'b0, 32'd1,         32'd0,        32'h0000_0001, 32'h8000_0000, 32'h0};
    vecs[4] = '{OP_MTLO, 1'b0, 32'd2,         32'd0,        32'h0000_0001, 32'h0000_0002, 32'h0};
    vecs[5] = '{OP_MADD, 1'b1, 32'd2,         32'd3,        32'h0000_0001, 32'h0000_0008, 32'h0};
    vecs[6] = '{OP_MSUB, 1'b1, 32'd4,         32'd3,        32'h0000_0000, 32'hFFFF_FFFC, 32'h0};
    vecs[7] = '{OP_MFHI, 1'b0, 32'h1234,      32'd0,        32'h0000_0000, 32'hFFFF_FFFC, 32'h0};
    vecs[8] = '{OP_MFLO, 1'b0, 32'h1234,      32'd0,        32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[9] = '{5'b11111, 1'b1, 32'h5555,     32'h7,        32'h0000_0000, 32'hFFFF_FFFC, 32'h0};

    // ---------------- reset ----------------
    Rst    = 1'b1;
    Start  = 1'b0;
    ALUOp2 = OP_MFLO;
    Signed = 1'b0;
    A      = '0;
    B      = '0;
    #2;
    Rst = 1'b0;
    tick();
    tick();
    chk("rst_busy",   Busy,   0);
    chk("rst_done",   Done,   0);
    chk("rst_hi",     HI,     0);
    chk("rst_lo",     LO,     0);
    chk("rst_result", Result, 0);
    Rst = 1'b1;
    tick();

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, t0);
      if (is_mult_op(vecs[i].op)) begin
        chk($sformatf("v%0d_busy_c1", i), Busy, 1);
        wait_done(t0, dc, bok);
        chk($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(LAT));
        chk($sformatf("v%0d_busy_window", i), bok, 1);
        chk($sformatf("v%0d_busy_in_done", i), Busy, 0);
      end else begin
        chk($sformatf("v%0d_no_busy", i), Busy, 0);
        chk($sformatf("v%0d_no_done", i), Done, 0);
      end
      chk($sformatf("v%0d_hi", i),     HI,     vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i),     LO,     vecs[i].exp_lo);
      chk($sformatf("v%0d_result", i), Result, vecs[i].exp_res);
      if (is_mult_op(vecs[i].op)) begin
        tick();
        chk($sformatf("v%0d_done_pulse", i), Done, 0);
      end
    end

    // ---------------- MTHI while busy is ignored ----------------
    issue(OP_MUL, 1'b0, 32'd5, 32'd6, t0);
    while (cyc - t0 < 5) tick();
    ALUOp2 = OP_MTHI;
    A      = 32'hDEAD;
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
    A      = '0;
    ALUOp2 = OP_MUL;
    chk("ign_hi_kept", HI, 0);
    chk("ign_busy",    Busy, 1);
    wait_done(t0, dc, bok);
    chk("ign_done_cycle", 64'(dc), 64'(LAT));
    chk("ign_busy_window", bok, 1);
    chk("ign_hi", HI, 0);
    chk("ign_lo", LO, 30);
    tick();

    // ---------------- reset mid-operation ----------------
    issue(OP_MUL, 1'b0, 32'd5, 32'd6, t0);
    while (cyc - t0 < 10) tick();
    chk("mid_busy_before", Busy, 1);
    Rst = 1'b0;
    #1;
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_done", Done, 0);
    chk("mid_rst_hi",   HI,   0);
    chk("mid_rst_lo",   LO,   0);
    tick();
    tick();
    Rst  = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      if (Done || Busy) seen = 1'b1;
      tick();
    end
    chk("mid_no_activity", seen, 0);
    issue(OP_MUL, 1'b0, 32'd5, 32'd6, t0);
    wait_done(t0, dc, bok);
    chk("mid_rerun_done_cycle", 64'(dc), 64'(LAT));
    chk("mid_rerun_lo", LO, 30);
    chk("mid_rerun_hi", HI, 0);
    tick();

    // ---------------- back-to-back in Done cycle ----------------
    issue(OP_MUL, 1'b1, 32'd2, 32'd2, t0);
    wait_done(t0, dc, bok);
    chk("b2b_first_done_cycle", 64'(dc), 64'(LAT));
    chk("b2b_first_lo", LO, 4);
    chk("b2b_first_result", Result, 4);
    issue(OP_MADD, 1'b1, 32'd1, 32'd1, t1);
    chk("b2b_second_accepted", Busy, 1);
    chk("b2b_second_done_low", Done, 0);
    wait_done(t1, dc, bok);
    chk("b2b_second_done_cycle", 64'(dc), 64'(LAT));
    chk("b2b_second_busy_window", bok, 1);
    chk("b2b_second_lo", LO, 5);
    chk("b2b_second_hi", HI, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Multi-cycle multiply / multiply-accumulate unit with architectural HI/LO registers.
- Sits in EX beside the main ALU and consumes the 5-bit ALUOp2 code produced by ALU control.
- Handles the mul/mult/multu, madd, msub, mthi/mtlo and mfhi/mflo class.
- The pipeline stalls on Busy.

Parameters:
- WIDTH, 32: operand width; HI and LO are WIDTH each, product is 2*WIDTH.
- OP_W, 5: width of the ALUOp2 code.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, asynchronous, active-low; clears all state immediately.
- Start  in  1  sample ALUOp2/A/B/Signed this cycle.
- ALUOp2  in  OP_W  op code from ALU control.
- Signed  in  1  1 = signed operands (mult/madd/msub), 0 = unsigned (multu).
- A  in  WIDTH  operand rs.
- B  in  WIDTH  operand rt.
- Busy  out  1  multiply in progress; upstream must hold Start low.
- Done  out  1  one-cycle pulse; HI/LO updated in the same cycle.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- Result  out  WIDTH  combinational: HI for MFHI, LO for MFLO or MUL, else 0.

Behaviour:
- Op codes:
  - MUL 5'b00010: HI:LO <= product.
  - MADD 5'b01011: HI:LO <= HI:LO + product.
  - MSUB 5'b01100: HI:LO <= HI:LO - product.
  - MTHI 5'b10010: HI <= A.
  - MTLO 5'b10011: LO <= A.
  - MFHI 5'b10100 and MFLO 5'b10101: read only.
  - Any other code with Start is ignored.
- Reset values: Busy=0, Done=0, HI=0, LO=0, state IDLE, iteration counter 0.
- States: IDLE, MUL, ACC.
- IDLE:
  - Start with a multiply-class op: capture |A|, |B|, product sign (Signed & (A[msb]^B[msb])), op and Signed; go to MUL; counter=0.
  - Start with MTHI/MTLO: write the register on that edge, stay IDLE, no Busy, no Done.
- MUL:
  - Radix-2 shift-add, one multiplier bit per cycle.
  - Counter increments each cycle; after WIDTH cycles go to ACC.
- ACC:
  - Negate the magnitude product if the sign flag is set.
  - Add to or subtract from HI:LO, or replace it, per op.
  - Register the result into HI/LO; Done <= 1; go to IDLE.
- Timing: Start high in cycle 0 -> Busy high in cycles 1..WIDTH+1 -> Done high and HI/LO new in cycle WIDTH+2 (34 for WIDTH=32). Busy is low in the Done cycle.
- Back-to-back: Start may be asserted in the Done cycle and is accepted.
- Start while Busy: ignored entirely, including MTHI/MTLO. No queuing; in-flight operation unaffected.
- Arithmetic: HI:LO arithmetic is modulo 2^(2*WIDTH); no overflow flag.
- Signed extremes: signed 0x80000000 * 0xFFFFFFFF gives product 2^31 (magnitude path is WIDTH+1 safe).
- Result:
  - Purely combinational from HI/LO and the current ALUOp2.
  - Valid regardless of Busy, but reads pre-update values while Busy.
  - For MUL, Result=LO is the rd value, valid in the Done cycle.
- Reset mid-operation: Rst low at any time forces IDLE, Busy=0, Done=0 and HI=LO=0 asynchronously. The partial product is discarded.
- Operand inputs are don't-care except in the Start cycle.

Optional Feature:
- Macro MULT_RADIX4_EN.
- Defined: radix-4 iteration, 2 multiplier bits per cycle. Partial products are 0, B, 2B, 3B; 3B is precomputed in the capture cycle. MUL lasts WIDTH/2 cycles, so Done arrives in cycle WIDTH/2+2 (18).
- Undefined: radix-2 as specified above, Done in cycle 34.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package hilo_pkg holds:
  - ALUOp2 code constants: OP_MUL, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO.
  - State encoding IDLE/MUL/ACC.
- Sub-module mult_iter_core (datapath only): shift-add multiplier with load/step inputs, product output and done-count flag.
- hilo_mult_unit owns the FSM, sign handling, accumulate, HI/LO and Result mux.

Test Plan:
- Signed MUL, A=0xFFFFFFFD (-3), B=7, Signed=1 -> Done cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB, Result=LO.
- Unsigned MUL, A=B=0xFFFFFFFF, Signed=0 -> HI=0xFFFFFFFE, LO=0x00000001. Signed extreme: A=0x80000000, B=0xFFFFFFFF, Signed=1 -> HI=0, LO=0x80000000.
- Accumulate sequence:
  - MTHI A=1, then MTLO A=2 (no Busy, HI=1, LO=2).
  - MADD A=2, B=3 -> HI=1, LO=8.
  - MSUB A=4, B=3 -> HI=0, LO=0xFFFFFFFC.
  - MFHI -> Result=0; MFLO -> Result=0xFFFFFFFC.
- Multiply A=5, B=6 started; at cycle 5 Start with MTHI A=0xDEAD -> ignored. Done at 34 gives HI=0, LO=30.
- MUL A=5, B=6 started; Rst low at cycle 10 -> Busy=0, HI=LO=0 immediately, no Done pulse. After release, MUL A=5, B=6 -> LO=30 at cycle 34.
- Start in the Done cycle of a MUL (A=2, B=2) with MADD A=1, B=1 -> first Done LO=4, second Done LO=5, no lost cycle.
